// File: rtl/bus_rr_if.sv
// Packet bus between the device FIFOs and the round-robin scheduler.
// The master side is the scheduler; the slave side is the device array.
interface bus_rr_if #(
    parameter int controladores = 5,
    parameter int BITS          = 16
);
    logic [controladores-1:0]           pndng;
    logic [controladores-1:0][BITS-1:0] D_pop;
    logic [controladores-1:0]           dest_full;
    logic [controladores-1:0]           pop;
    logic [controladores-1:0]           push;
    logic [BITS-1:0]                    D_push;

    modport master (
        input  pndng, D_pop, dest_full,
        output pop, push, D_push
    );

    modport slave (
        output pndng, D_pop, dest_full,
        input  pop, push, D_push
    );
endinterface

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler: pops one packet from a pending device FIFO,
// decodes its destination ID and pushes it to one device or broadcasts it.
module bus_rr_scheduler #(
    parameter int controladores = 5,
    parameter int BITS          = 16,
    parameter int broadcast     = 145
) (
    input  logic       clk,
    input  logic       reset,
    bus_rr_if.master   bus,
    output logic [3:0] grant_id,
    output logic       busy,
    output logic       drop
);
    localparam int             N    = controladores;
    localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [3:0]     LAST = 4'(N - 1);
    localparam logic [4:0]     N5   = 5'(N);
    localparam logic [7:0]     BCID = 8'(broadcast);
    localparam logic [7:0]     N8   = 8'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [3:0]      rr_ptr_r, rr_ptr_s;
    logic [3:0]      grant_r, grant_s;
    logic [BITS-1:0] data_r, data_s;
    logic [N-1:0]    tgt_r, tgt_s;

    logic [2*N-1:0]  rot_s;
    logic [3:0]      pos_s;
    logic [4:0]      sum_s;
    logic [3:0]      pick_s;
    logic [BITS-1:0] head_s;
    logic [7:0]      dst_s;
    logic [N-1:0]    route_s;
    logic            valid_s;
    logic [3:0]      next_ptr_s;

    assign grant_id = grant_r;

    // Rotate pending so bit 0 is rr_ptr; the lowest set bit wins, then un-rotate modulo N
    always_comb begin
        rot_s = {bus.pndng, bus.pndng} >> rr_ptr_r;
        pos_s = 4'd0;
        for (int j = N - 1; j >= 0; j--) begin
            pos_s = rot_s[j] ? 4'(j) : pos_s;
        end
        sum_s  = {1'b0, rr_ptr_r} + {1'b0, pos_s};
        pick_s = (sum_s >= N5) ? 4'(sum_s - N5) : sum_s[3:0];
    end

    // Head word of the granted device FIFO
    always_comb begin
        head_s = '0;
        for (int i = 0; i < N; i++) begin
            head_s = (grant_r == 4'(i)) ? bus.D_pop[i] : head_s;
        end
    end

    // Destination decode of the latched packet
    always_comb begin
        dst_s      = data_r[BITS-1:BITS-8];
        next_ptr_s = (grant_r == LAST) ? 4'd0 : grant_r + 4'd1;
        if (dst_s == BCID) begin
            route_s = ~(ONE << grant_r);
            valid_s = 1'b1;
        end else if (dst_s < N8) begin
            route_s = ONE << dst_s[3:0];
            valid_s = 1'b1;
        end else begin
            route_s = '0;
            valid_s = 1'b0;
        end
    end

    // Next-state and strobe decode; push is held off until every target has room
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        grant_s    = grant_r;
        data_s     = data_r;
        tgt_s      = tgt_r;
        bus.pop    = '0;
        bus.push   = '0;
        bus.D_push = '0;
        drop       = 1'b0;
        busy       = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (|bus.pndng) begin
                    grant_s = pick_s;
                    state_s = POP;
                end else begin
                    state_s = IDLE;
                end
            end
            POP: begin
                bus.pop = ONE << grant_r;
                data_s  = head_s;
                state_s = ROUTE;
            end
            ROUTE: begin
                if (valid_s) begin
                    tgt_s   = route_s;
                    state_s = PUSH;
                end else begin
                    drop     = 1'b1;
                    rr_ptr_s = next_ptr_s;
                    state_s  = IDLE;
                end
            end
            PUSH: begin
                bus.D_push = data_r;
                if ((tgt_r & bus.dest_full) == '0) begin
                    bus.push = tgt_r;
                    rr_ptr_s = next_ptr_s;
                    state_s  = IDLE;
                end else begin
                    state_s = PUSH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            rr_ptr_r <= 4'd0;
            grant_r  <= 4'd0;
            data_r   <= '0;
            tgt_r    <= '0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            grant_r  <= grant_s;
            data_r   <= data_s;
            tgt_r    <= tgt_s;
        end
    end
endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler for the shared packet bus between `controladores` device FIFOs. It picks one device with a pending packet, pops that packet, and decodes the destination ID in the packet's upper byte. It then pushes the packet to the destination device, or to every other device when the ID is the broadcast ID. The block sits between the per-device FIFO interface (`pndng`/`pop`/`D_pop` toward the sources, `push`/`D_push` toward the destinations) and adds per-destination backpressure and drop reporting.

## Interface
- `controladores`, default 5: number of devices N, 2..16.
- `BITS`, default 16: packet width, at least 9. Bits [BITS-1:BITS-8] are the destination ID; the remaining bits are payload.
- `broadcast`, default 145: destination ID meaning "all devices except the source".
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `pndng` input, N bits: bit i high means device i's FIFO is non-empty and its head word is on `D_pop[i]` (show-ahead).
- `D_pop` input, N x BITS: head word of each device FIFO.
- `dest_full` input, N bits: bit i high means device i cannot accept a push this cycle.
- `pop` output, N bits: one-cycle pop strobe to the granted device FIFO.
- `push` output, N bits: push strobe, one bit per destination.
- `D_push` output, BITS: packet presented with `push`.
- `grant_id` output, 4 bits: index of the device currently being served.
- `busy` output, 1 bit: high in every state except IDLE.
- `drop` output, 1 bit: one-cycle pulse when a packet with an invalid destination is discarded.

## Operation
- The FSM has four states: IDLE, POP, ROUTE, PUSH.
- IDLE:
  - If `pndng` is nonzero, select the first set bit searching upward from `rr_ptr` with wrap-around, register it into `grant_id`, and go to POP.
  - Otherwise stay in IDLE.
- POP:
  - `pop[grant_id]`=1 for exactly this cycle.
  - `data_reg` <= `D_pop[grant_id]`.
  - Next state is ROUTE.
- ROUTE:
  - `dst` = `data_reg[BITS-1:BITS-8]`.
  - If `dst`==`broadcast`, `tgt_mask` = all ones with the `grant_id` bit cleared.
  - Else if `dst` < N, `tgt_mask` = one-hot(`dst`). A device may address itself.
  - Else the packet is invalid: `drop`=1 this cycle, `rr_ptr` <= (`grant_id`+1) mod N, and the FSM returns to IDLE.
  - A valid packet goes to PUSH.
- PUSH:
  - If (`tgt_mask` & `dest_full`)==0: `push`=`tgt_mask` and `D_push`=`data_reg` this cycle, `rr_ptr` <= (`grant_id`+1) mod N, and the FSM returns to IDLE.
  - Otherwise `push`=0 and the FSM stays in PUSH. A broadcast is never partially delivered.
- The `rr_ptr` comparison is modulo N; `rr_ptr`=N-1 wraps to 0.
- `pndng` dropping during ROUTE or PUSH has no effect, because the packet is already latched.
- A source FIFO is popped only in POP, so at most one pop is asserted per packet.
- Reset: state=IDLE, `rr_ptr`=0, `grant_id`=0, `data_reg`=0. On reset every output is 0: `pop`, `push`, `D_push`, `busy`, `drop`.
- Reset asserted mid-operation aborts immediately: the latched packet is lost and no push or pop is issued afterwards.

## Timing
- `pop`, `push` and `drop` are single-cycle strobes decoded from registered state.
- `push` is additionally gated combinationally by `dest_full` in PUSH.
- `D_push` holds `data_reg` throughout PUSH and is 0 in all other states.
- Minimum latency, `pndng` sampled high in IDLE (edge T):
  - `pop` high in cycle T+1.
  - `push` high in cycle T+3.
  - IDLE again at T+4.
- Peak throughput is one packet per 4 cycles.
- An invalid packet takes 3 cycles from grant to `drop` and back to IDLE.
- Each cycle of `dest_full` blocking adds exactly one cycle.
- `busy` is high from the cycle after the IDLE decision until the cycle the FSM re-enters IDLE.

## Test plan
- **Single unicast.** Reset, then `pndng`=00001 with `D_pop[0]`=0x0203 (dst 2, payload 0x03). Required:
  - `pop`=00001 at T+1.
  - `push`=00100 and `D_push`=0x0203 at T+3.
  - `drop` never asserted.
- **Broadcast.** Device 3 sends dst 145 (0x9155) with N=5. Required:
  - `push`=10111 and `D_push`=0x9155 in a single cycle.
  - `grant_id`=3 during service.
- **Round-robin fairness.** `pndng`=11111 held continuously, each device addressing device 0. Required:
  - Grants occur in order 0,1,2,3,4,0, one every 4 cycles.
  - No device is granted twice before every pending device has been granted once.
- **Backpressure.** Unicast to device 1 with `dest_full[1]`=1 for 6 cycles. Required:
  - PUSH is held for 6 cycles with `push`=0.
  - `push`=00010 on the first cycle `dest_full[1]`=0.
  - Broadcast variant: any single full target blocks the whole push.
- **Invalid destination.** Device 2 sends dst 7 with N=5. Required:
  - `pop`=00100.
  - `drop` pulses at T+2.
  - No `push` is issued.
  - The next grant searches from device 3.
- **Reset mid-operation.** Assert `reset`=0 during PUSH while `dest_full` is blocking. Required:
  - All outputs read 0 immediately.
  - After release, `rr_ptr`=0 and the first grant goes to the lowest pending device.
